// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Requester 0 is the execute stage, requester 1 is the auxiliary
// address/compare unit. Each cycle at most one eligible request is granted,
// its operands are driven to the ALU, and the ALU result is captured into
// that requester's response slot, which is drained with a valid/ready
// handshake.
//
// Build option: define ALU_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority when both requesters are eligible. Without it, contended grants
// alternate round-robin.
module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic [XLEN-1:0] req1_b,
  input  logic [3:0]      req0_ctrl,
  input  logic [3:0]      req1_ctrl,
  input  logic [2:0]      req0_bctrl,
  input  logic [2:0]      req1_bctrl,
  input  logic [TAGW-1:0] req0_tag,
  input  logic [TAGW-1:0] req1_tag,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  output logic [2:0]      alu_bctrl,
  input  logic [XLEN-1:0] alu_result,
  output logic [1:0]      rsp_valid,
  input  logic [1:0]      rsp_ready,
  output logic [XLEN-1:0] rsp0_data,
  output logic [XLEN-1:0] rsp1_data,
  output logic [TAGW-1:0] rsp0_tag,
  output logic [TAGW-1:0] rsp1_tag,
  output logic            busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // Requester fields gathered into indexable vectors for the per-slot logic.
  logic [1:0][TAGW-1:0] req_tag;
  logic [1:0][XLEN-1:0] rsp_data;
  logic [1:0][TAGW-1:0] rsp_tag;
  logic [1:0]           elig;
  logic [1:0]           grant;

  assign req_tag   = {req1_tag, req0_tag};
  assign rsp0_data = rsp_data[0];
  assign rsp1_data = rsp_data[1];
  assign rsp0_tag  = rsp_tag[0];
  assign rsp1_tag  = rsp_tag[1];

  // Per-requester response slot: two-state FSM plus captured data and tag.
  // A full slot can accept a new result in the same cycle it is drained,
  // which is what gives one result per cycle to a single requester.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      slot_state_t     state_reg;
      slot_state_t     state_next;
      logic [XLEN-1:0] data_reg;
      logic [TAGW-1:0] tag_reg;

      assign elig[gi]      = req_valid[gi] && ((state_reg == EMPTY) || rsp_ready[gi]);
      assign rsp_valid[gi] = (state_reg == FULL);
      assign rsp_data[gi]  = data_reg;
      assign rsp_tag[gi]   = tag_reg;

      // Slot state register.
      always_ff @(posedge clk) begin
        if (reset) begin
          state_reg <= EMPTY;
        end else begin
          state_reg <= state_next;
        end
      end

      // Slot next state: fill on grant, empty on drain without refill.
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          EMPTY: begin
            if (grant[gi]) state_next = FULL;
          end
          FULL: begin
            if (grant[gi])          state_next = FULL;
            else if (rsp_ready[gi]) state_next = EMPTY;
          end
          default: state_next = EMPTY;
        endcase
      end

      // Capture the ALU result and the request tag on the granting edge.
      always_ff @(posedge clk) begin
        if (reset) begin
          data_reg <= '0;
          tag_reg  <= '0;
        end else if (grant[gi]) begin
          data_reg <= alu_result;
          tag_reg  <= req_tag[gi];
        end
      end
    end
  endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins any contention; nothing granted in reset.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (elig == 2'b11) grant = 2'b01;
      else               grant = elig;
    end
  end
`else
  logic rr_ptr_reg;

  // Round-robin pointer: after a grant, the other requester is preferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= 1'b0;
    end else if (|grant) begin
      rr_ptr_reg <= grant[0];
    end
  end

  // Round-robin arbitration; contention resolved by the pointer.
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      if (elig == 2'b11) grant = rr_ptr_reg ? 2'b10 : 2'b01;
      else               grant = elig;
    end
  end
`endif

  assign req_ready = grant;

  // ALU operand mux; idle cycles present MOVEA on the non-branch path with zeros.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = 4'd0;
    alu_bctrl = 3'd0;
    if (grant[0]) begin
      alu_a     = req0_a;
      alu_b     = req0_b;
      alu_ctrl  = req0_ctrl;
      alu_bctrl = req0_bctrl;
    end else if (grant[1]) begin
      alu_a     = req1_a;
      alu_b     = req1_b;
      alu_ctrl  = req1_ctrl;
      alu_bctrl = req1_bctrl;
    end
  end

  assign busy = (|req_valid) || (|rsp_valid);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector table for the scripted corner cases, then
// randomized traffic compared against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int XLEN = 32;
  localparam int TAGW = 4;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [3:0] C_MOVEA = 4'd0, C_ADD = 4'd1, C_SUB = 4'd2;
  localparam logic [2:0] B_NONE = 3'd0, B_BLT = 3'd3;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [XLEN-1:0] req0_a, req1_a, req0_b, req1_b;
  logic [3:0]      req0_ctrl, req1_ctrl, alu_ctrl;
  logic [2:0]      req0_bctrl, req1_bctrl, alu_bctrl;
  logic [TAGW-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic [XLEN-1:0] alu_a, alu_b, alu_result, rsp0_data, rsp1_data;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_bctrl(req0_bctrl), .req1_bctrl(req1_bctrl),
    .req0_tag(req0_tag), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_bctrl(alu_bctrl),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .rsp0_tag(rsp0_tag), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  // Behavioural stand-in for the shared ALU.
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] c, input logic [2:0] bc);
    case (bc)
      3'd1:    return {31'b0, a == b};
      3'd3:    return {31'b0, $signed(a) < $signed(b)};
      3'd5:    return {31'b0, a < b};
      default: begin
        case (c)
          4'd1:    return a + b;
          4'd2:    return a - b;
          4'd3:    return a & b;
          4'd4:    return a | b;
          4'd5:    return a ^ b;
          default: return a;
        endcase
      end
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_a, alu_b, alu_ctrl, alu_bctrl);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] vld, input logic [1:0] rdy,
                       input logic [3:0] c0, input logic [2:0] bc0, input logic [31:0] a0,
                       input logic [31:0] b0, input logic [3:0] t0,
                       input logic [3:0] c1, input logic [2:0] bc1, input logic [31:0] a1,
                       input logic [31:0] b1, input logic [3:0] t1);
    reset = rst; req_valid = vld; rsp_ready = rdy;
    req0_ctrl = c0; req0_bctrl = bc0; req0_a = a0; req0_b = b0; req0_tag = t0;
    req1_ctrl = c1; req1_bctrl = bc1; req1_a = a1; req1_b = b1; req1_tag = t1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  vld, rdy;
    logic [3:0]  c0;
    logic [31:0] a0, b0;
    logic [3:0]  t0;
    logic [3:0]  c1;
    logic [2:0]  bc1;
    logic [31:0] a1, b1;
    logic [3:0]  t1;
    logic [1:0]  eg, erv;
    logic [31:0] ed0;
    logic [3:0]  et0;
    logic [31:0] ed1;
    logic [3:0]  et1;
    logic        dz;   // slot data/tag expected to be reset zeros
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] vld, input logic [1:0] rdy,
                              input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                              input logic [3:0] t0, input logic [3:0] c1, input logic [2:0] bc1,
                              input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1,
                              input logic [1:0] eg, input logic [1:0] erv,
                              input logic [31:0] ed0, input logic [3:0] et0,
                              input logic [31:0] ed1, input logic [3:0] et1, input logic dz);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rdy = rdy;
    v.c0 = c0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
    v.c1 = c1; v.bc1 = bc1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
    v.eg = eg; v.erv = erv; v.ed0 = ed0; v.et0 = et0; v.ed1 = ed1; v.et1 = et1; v.dz = dz;
    return v;
  endfunction

  vec_t vecs[$];

  // Random-phase requester state and reference model state.
  logic        rv_v[2];
  logic [31:0] rv_a[2], rv_b[2];
  logic [3:0]  rv_c[2], rv_t[2];
  logic [2:0]  rv_bc[2];
  bit          m_full[2];
  logic [31:0] m_data[2];
  logic [3:0]  m_tag[2];
  int          m_prefer;
  int          last_win;

  initial begin
    // Test 1: single ADD, then idle (also covers the no-request case).
    vecs.push_back(mk(0, 2'b01, 2'b01, C_ADD, 5, 7, 3, C_MOVEA, B_NONE, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 2'b00, 2'b01, C_ADD, 5, 7, 3, C_MOVEA, B_NONE, 0, 0, 0, 2'b00, 2'b01, 12, 3, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    // Test 2: both requesting with both responses ready, from a fresh reset.
    vecs.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, C_ADD, 1, 2, 4, C_ADD, B_NONE, 10, 20, 5, 2'b01, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 2'b11, 2'b11, C_ADD, 1, 2, 4, C_ADD, B_NONE, 10, 20, 5, FIXED ? 2'b01 : 2'b10, 2'b01, 3, 4, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, C_ADD, 1, 2, 4, C_ADD, B_NONE, 10, 20, 5, 2'b01, FIXED ? 2'b01 : 2'b10, 3, 4, 30, 5, 0));
    vecs.push_back(mk(0, 2'b11, 2'b11, C_ADD, 1, 2, 4, C_ADD, B_NONE, 10, 20, 5, FIXED ? 2'b01 : 2'b10, 2'b01, 3, 4, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, FIXED ? 2'b01 : 2'b10, 3, 4, 30, 5, 0));
    // Test 3: BLT on requester 1 held by back-pressure, second request waits.
    vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 0, 0, C_MOVEA, B_BLT, 32'hFFFF_FFFF, 1, 6, 2'b10, 2'b00, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 2'b10, 2'b00, 0, 0, 0, 0, C_MOVEA, B_BLT, 5, 3, 7, 2'b00, 2'b10, 0, 0, 1, 6, 0));
    vecs.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0, 0, C_MOVEA, B_BLT, 5, 3, 7, 2'b10, 2'b10, 0, 0, 1, 6, 0));
    vecs.push_back(mk(0, 2'b00, 2'b10, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, 2'b10, 0, 0, 0, 7, 0));
    // Test 4: three back-to-back SUBs on requester 0.
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 2'b01, 2'b01, C_SUB, 32'h10, 32'h20, k[3:0], 0, B_NONE, 0, 0, 0, 2'b01,
                        (k == 0) ? 2'b00 : 2'b01, 32'hFFFF_FFF0, 4'(k - 1), 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, 2'b01, 32'hFFFF_FFF0, 2, 0, 0, 0));
    // Test 5: reset while slot 0 is full and both requesters are valid.
    vecs.push_back(mk(0, 2'b01, 2'b00, C_ADD, 1, 1, 9, C_ADD, B_NONE, 8, 8, 10, 2'b01, 2'b00, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2'b11, 2'b00, C_ADD, 1, 1, 9, C_ADD, B_NONE, 8, 8, 10, 2'b00, 2'b01, 2, 9, 0, 0, 0));
    vecs.push_back(mk(0, 2'b11, 2'b00, C_ADD, 1, 1, 9, C_ADD, B_NONE, 8, 8, 10, 2'b01, 2'b00, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 2'b00, 2'b11, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, 2'b01, 2, 9, 0, 0, 0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, B_NONE, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

    // Initial reset with both requesters valid: nothing may be granted.
    drive(1, 2'b11, 2'b00, C_ADD, B_NONE, 1, 1, 1, C_ADD, B_NONE, 2, 2, 2);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_req_ready", req_ready, 2'b00);
      @(posedge clk); #1;
    end

    foreach (vecs[k]) begin
      vec_t v;
      logic [31:0] ea, eb;
      logic [3:0]  ec;
      logic [2:0]  ebc;
      v = vecs[k];
      drive(v.rst, v.vld, v.rdy, v.c0, B_NONE, v.a0, v.b0, v.t0, v.c1, v.bc1, v.a1, v.b1, v.t1);
      ea = 0; eb = 0; ec = 0; ebc = 0;
      if (v.eg == 2'b01) begin ea = v.a0; eb = v.b0; ec = v.c0; ebc = B_NONE; end
      if (v.eg == 2'b10) begin ea = v.a1; eb = v.b1; ec = v.c1; ebc = v.bc1; end
      @(negedge clk);
      $display("vec %0d: rst=%0b vld=%b rdy=%b req_ready=%b rsp_valid=%b d0=%h t0=%0d d1=%h t1=%0d",
               k, v.rst, v.vld, v.rdy, req_ready, rsp_valid, rsp0_data, rsp0_tag, rsp1_data, rsp1_tag);
      chk("vec_req_ready", req_ready, v.eg);
      chk("vec_rsp_valid", rsp_valid, v.erv);
      if (v.erv[0] || v.dz) begin
        chk("vec_rsp0_data", rsp0_data, v.dz ? 32'd0 : v.ed0);
        chk("vec_rsp0_tag", rsp0_tag, v.dz ? 4'd0 : v.et0);
      end
      if (v.erv[1] || v.dz) begin
        chk("vec_rsp1_data", rsp1_data, v.dz ? 32'd0 : v.ed1);
        chk("vec_rsp1_tag", rsp1_tag, v.dz ? 4'd0 : v.et1);
      end
      chk("vec_alu_a", alu_a, ea);
      chk("vec_alu_b", alu_b, eb);
      chk("vec_alu_ctrl", {alu_ctrl, alu_bctrl}, {ec, ebc});
      chk("vec_busy", busy, (|v.vld) || (|v.erv));
      @(posedge clk); #1;
    end

    // Randomized traffic against the reference model, starting from reset.
    drive(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0; m_data[i] = 0; m_tag[i] = 0; rv_v[i] = 0;
      rv_a[i] = 0; rv_b[i] = 0; rv_c[i] = 0; rv_bc[i] = 0; rv_t[i] = 0;
    end
    m_prefer = 0;
    last_win = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic       rst;
      logic [1:0] rdy, eg;
      bit         el[2];
      int         win;
      logic [31:0] ea, eb;
      logic [3:0]  ec;
      logic [2:0]  ebc;
      for (int i = 0; i < 2; i++) begin
        if (!(rv_v[i] && last_win != i && $urandom_range(0, 9) != 0)) begin
          logic [2:0] bsel;
          bsel = 3'($urandom_range(0, 4));
          rv_v[i]  = ($urandom_range(0, 2) != 0);
          rv_a[i]  = $urandom;
          rv_b[i]  = ($urandom_range(0, 3) == 0) ? rv_a[i] : $urandom;
          rv_c[i]  = 4'($urandom_range(0, 5));
          rv_bc[i] = (bsel == 3'd2) ? 3'd1 : (bsel == 3'd3) ? 3'd3 : (bsel == 3'd4) ? 3'd5 : 3'd0;
          rv_t[i]  = 4'($urandom);
        end
      end
      rdy = 2'($urandom);
      rst = ($urandom_range(0, 49) == 0);
      drive(rst, {rv_v[1], rv_v[0]}, rdy, rv_c[0], rv_bc[0], rv_a[0], rv_b[0], rv_t[0],
            rv_c[1], rv_bc[1], rv_a[1], rv_b[1], rv_t[1]);

      for (int i = 0; i < 2; i++) el[i] = !rst && rv_v[i] && (!m_full[i] || rdy[i]);
      if (el[0] && el[1]) win = FIXED ? 0 : m_prefer;
      else if (el[0])     win = 0;
      else if (el[1])     win = 1;
      else                win = -1;
      eg  = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
      ea  = (win >= 0) ? rv_a[win]  : 32'd0;
      eb  = (win >= 0) ? rv_b[win]  : 32'd0;
      ec  = (win >= 0) ? rv_c[win]  : 4'd0;
      ebc = (win >= 0) ? rv_bc[win] : 3'd0;

      @(negedge clk);
      chk("rnd_req_ready", req_ready, eg);
      chk("rnd_rsp_valid", rsp_valid, {m_full[1], m_full[0]});
      if (m_full[0]) chk("rnd_rsp0", {rsp0_tag, rsp0_data}, {m_tag[0], m_data[0]});
      if (m_full[1]) chk("rnd_rsp1", {rsp1_tag, rsp1_data}, {m_tag[1], m_data[1]});
      chk("rnd_alu_ab", {alu_a, alu_b}, {ea, eb});
      chk("rnd_alu_ctrl", {alu_ctrl, alu_bctrl}, {ec, ebc});
      chk("rnd_busy", busy, rv_v[0] || rv_v[1] || m_full[0] || m_full[1]);
      @(posedge clk); #1;

      if (rst) begin
        for (int i = 0; i < 2; i++) begin m_full[i] = 0; m_data[i] = 0; m_tag[i] = 0; end
        m_prefer = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (win == i) begin
            m_full[i] = 1;
            m_data[i] = alu_f(rv_a[i], rv_b[i], rv_c[i], rv_bc[i]);
            m_tag[i]  = rv_t[i];
          end else if (m_full[i] && rdy[i]) begin
            m_full[i] = 0;
          end
        end
        if (win >= 0) m_prefer = 1 - win;
      end
      last_win = win;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational alu instance between two requesters: port 0 is the execute stage and port 1 is the auxiliary address/compare unit. The block arbitrates each cycle, drives the shared alu operand and control inputs from the granted request, and registers the alu result into a per-requester response slot. Each response slot has a valid/ready handshake and returns the request's tag. It sits between the pipeline's issue logic and the alu.

Parameters:
XLEN, 32, operand/result width (matches `XLEN)
TAGW, 4, width of the request tag carried to the response

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  2  request valid, bit i = requester i
req_ready  out  2  request accepted this cycle (one-hot or zero)
req0_a, req1_a  in  XLEN  operand A per requester
req0_b, req1_b  in  XLEN  operand B per requester
req0_ctrl, req1_ctrl  in  4  alu control code per requester
req0_bctrl, req1_bctrl  in  3  branch control code per requester
req0_tag, req1_tag  in  TAGW  request tag
alu_a, alu_b  out  XLEN  to shared alu
alu_ctrl  out  4  to shared alu
alu_bctrl  out  3  to shared alu
alu_result  in  XLEN  from shared alu (combinational)
rsp_valid  out  2  response slot i holds a result
rsp_ready  in  2  requester i consumes its response
rsp0_data, rsp1_data  out  XLEN  registered result
rsp0_tag, rsp1_tag  out  TAGW  tag of the registered result
busy  out  1  any req_valid or any rsp_valid asserted

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - rsp_valid=0, rsp*_data=0, rsp*_tag=0, rr_ptr=0.
  - Any in-flight or unconsumed result is discarded.
  - A request presented on the reset cycle is not granted: req_ready=0 while reset=1.
- Slot i is a 2-state FSM:
  - EMPTY -> FULL on grant[i].
  - FULL -> EMPTY on rsp_valid[i] && rsp_ready[i] with no new grant[i].
  - FULL -> FULL on drain with a simultaneous grant[i] (back-to-back, data/tag replaced).
  - rsp_valid[i] = (state == FULL).
- Eligibility: elig[i] = req_valid[i] && (slot i EMPTY || rsp_ready[i]).
- Arbitration (combinational, at most one grant per cycle):
  - Only one eligible: grant it.
  - Both eligible: grant rr_ptr.
  - After any grant g: rr_ptr <= ~g. No grant: rr_ptr holds.
- req_ready = grant (one-hot or zero).
- A transfer occurs when req_valid[i] && req_ready[i]. Requesters hold their inputs stable while valid && !ready. Deasserting valid before the grant is legal and loses nothing.
- ALU drive (combinational):
  - On grant[i]: alu_a/alu_b/alu_ctrl/alu_bctrl = requester i fields.
  - No grant: all zero. bctrl=0 selects the non-branch path, ctrl=0 is MOVEA.
- Capture on the granting edge: rsp_i_data <= alu_result, rsp_i_tag <= req_i_tag.
- Latency: request granted in cycle N -> rsp_valid[i]=1 and data visible in cycle N+1.
- Throughput: 1 result per cycle total. A single requester with rsp_ready held high is granted every cycle.
- Width rules: data and tag captured unmodified. No arithmetic in this block; branch results arrive as 0/1 in bit 0 from the alu.
- rsp_ready[i] while rsp_valid[i]=0 is ignored.
- busy = |req_valid | |rsp_valid.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are eligible; rr_ptr is not implemented and requester 1 can starve.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, then req0 ADD a=5 b=7 tag=3, rsp_ready[0]=1 -> req_ready=01 in cycle N; cycle N+1: rsp_valid=01, rsp0_data=12, rsp0_tag=3.
2. Both valid for 4 cycles, both rsp_ready=1 -> grants 01,10,01,10; rsp tags alternate. With ALU_ARB_FIXED_PRIO_EN the grants are 01,01,01,01.
3. req1 BLT a=0xFFFFFFFF (-1) b=1, rsp_ready[1]=0 for 3 cycles -> rsp1_data=1 held stable for those 3 cycles. A second req1 is not granted (req_ready[1]=0) until the cycle rsp_ready[1]=1, then slot refills the next cycle.
4. req0 SUB a=0x10 b=0x20 with rsp_ready[0] held 1 for 3 back-to-back requests (tags 0,1,2) -> rsp_valid[0] stays 1 for 3 cycles, rsp0_data=0xFFFFFFF0, tags 0,1,2 in order.
5. Slot 0 FULL, reset asserted for 1 cycle with req_valid=11 -> next cycle rsp_valid=00, data/tags 0, req_ready was 00 during reset, rr_ptr=0 (req0 wins the first contended grant).
6. No requests -> alu_a=alu_b=0, alu_ctrl=0, alu_bctrl=0, busy=0, rsp_valid unchanged.
